medidor_faixa_uc: RTL and testbench

Control unit (FSM) that sequences the range-meter datapath: ultrasonic measurement, serial transmission of the 4-char frame (unidade, dezena, centena, '#'), 250 ms pacing interval and 3 s "acertou" win detection. It sits beside the datapath inside the game top level. It drives every datapath control strobe and consumes its status flags. It adds measurement-timeout retry and an error state.

---
 rtl/medidor_faixa_pkg.sv | 34 +++
 rtl/medidor_faixa_uc.sv | 127 ++++++++++++
 tb/tb_medidor_faixa_uc.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/medidor_faixa_pkg.sv
// Shared definitions for the range-meter game: state codes, the frame
// terminator character and the default measurement retry limit.
package medidor_faixa_pkg;

  localparam logic [3:0] ST_INICIAL       = 4'd0;
  localparam logic [3:0] ST_PREPARA       = 4'd1;
  localparam logic [3:0] ST_MEDE          = 4'd2;
  localparam logic [3:0] ST_ESPERA_MEDIDA = 4'd3;
  localparam logic [3:0] ST_TRANSMITE     = 4'd4;
  localparam logic [3:0] ST_ESPERA_TX     = 4'd5;
  localparam logic [3:0] ST_PROX_CHAR     = 4'd6;
  localparam logic [3:0] ST_INTERVALO     = 4'd7;
  localparam logic [3:0] ST_ACERTO        = 4'd8;
  localparam logic [3:0] ST_ERRO          = 4'd15;

  typedef enum logic [3:0] {
    INICIAL       = ST_INICIAL,
    PREPARA       = ST_PREPARA,
    MEDE          = ST_MEDE,
    ESPERA_MEDIDA = ST_ESPERA_MEDIDA,
    TRANSMITE     = ST_TRANSMITE,
    ESPERA_TX     = ST_ESPERA_TX,
    PROX_CHAR     = ST_PROX_CHAR,
    INTERVALO     = ST_INTERVALO,
    ACERTO        = ST_ACERTO,
    ERRO          = ST_ERRO
  } estado_t;

  // Last character of every serial frame, also used by the datapath mux.
  localparam logic [7:0] ASCII_HASH = 8'h23;

  localparam int MAX_RETRY_DEFAULT = 3;

endpackage

// File: rtl/medidor_faixa_uc.sv
// Control unit of the range meter: sequences measurement, 4-char serial frame,
// 250 ms pacing and win detection, with measurement-timeout retry and error.
module medidor_faixa_uc
  import medidor_faixa_pkg::*;
#(
  parameter int MAX_RETRY = MAX_RETRY_DEFAULT,
  parameter int RETRY_W   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       iniciar,
  input  logic       pronto_medida,
  input  logic       pronto_tx,
  input  logic       is_ultimo_char,
  input  logic       fim_time,
  input  logic       acertou,
  output logic       zera,
  output logic       zera_time,
  output logic       zera_char,
  output logic       mensurar,
  output logic       conta_time,
  output logic       partida_tx,
  output logic       conta_prox_char,
  output logic       ganhou,
  output logic       erro,
  output logic [3:0] db_estado
);

  estado_t              r_state;
  estado_t              w_next;
  logic [RETRY_W-1:0]   r_retry;
  logic [RETRY_W-1:0]   w_retry_inc;
  logic                 r_intervalo_run;

  assign w_retry_inc = r_retry + RETRY_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= INICIAL;
      r_retry         <= '0;
      r_intervalo_run <= 1'b0;
    end else begin
      r_state         <= w_next;
      // Low only on the first INTERVALO cycle, which clears the char selector.
      r_intervalo_run <= (r_state == INTERVALO);
      if (r_state == PREPARA) begin
        r_retry <= '0;
      end else if (r_state == ESPERA_MEDIDA) begin
        if (pronto_medida) begin
          r_retry <= '0;
        end else if (fim_time) begin
          r_retry <= w_retry_inc;
        end
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    zera            = 1'b0;
    zera_time       = 1'b0;
    zera_char       = 1'b0;
    mensurar        = 1'b0;
    conta_time      = 1'b0;
    partida_tx      = 1'b0;
    conta_prox_char = 1'b0;
    ganhou          = 1'b0;
    erro            = 1'b0;

    case (r_state)
      INICIAL: begin
        if (ligar && iniciar) w_next = PREPARA;
      end
      PREPARA: begin
        zera      = 1'b1;
        zera_time = 1'b1;
        zera_char = 1'b1;
        w_next    = MEDE;
      end
      MEDE: begin
        mensurar  = 1'b1;
        zera_time = 1'b1;
        w_next    = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        conta_time = 1'b1;
        if (pronto_medida) begin
          w_next = TRANSMITE;
        end else if (fim_time) begin
          w_next = (w_retry_inc == RETRY_W'(MAX_RETRY)) ? ERRO : MEDE;
        end
      end
      TRANSMITE: begin
        partida_tx = 1'b1;
        w_next     = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (pronto_tx) w_next = is_ultimo_char ? INTERVALO : PROX_CHAR;
      end
      PROX_CHAR: begin
        conta_prox_char = 1'b1;
        w_next          = TRANSMITE;
      end
      INTERVALO: begin
        if (r_intervalo_run) conta_time = 1'b1;
        else                 zera_char  = 1'b1;
        if (fim_time) w_next = acertou ? ACERTO : MEDE;
      end
      ACERTO: begin
        ganhou = 1'b1;
        if (iniciar) w_next = PREPARA;
      end
      ERRO: begin
        erro = 1'b1;
        if (iniciar) w_next = PREPARA;
      end
      default: w_next = INICIAL;
    endcase

    // Turning the game off aborts anything in flight, including a frame.
    if (!ligar && (r_state != INICIAL)) w_next = INICIAL;
  end

  assign db_estado = r_state;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Directed bench for medidor_faixa_uc: stimulus pushes the expected state
// sequence into a queue, a monitor pops and compares on every state change.
module tb_medidor_faixa_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar, iniciar, pronto_medida, pronto_tx, is_ultimo_char;
  logic       fim_time, acertou;
  logic       zera, zera_time, zera_char, mensurar, conta_time;
  logic       partida_tx, conta_prox_char, ganhou, erro;
  logic [3:0] db_estado;

  medidor_faixa_uc dut (
    .clock(clock), .reset(reset), .ligar(ligar), .iniciar(iniciar),
    .pronto_medida(pronto_medida), .pronto_tx(pronto_tx),
    .is_ultimo_char(is_ultimo_char), .fim_time(fim_time), .acertou(acertou),
    .zera(zera), .zera_time(zera_time), .zera_char(zera_char),
    .mensurar(mensurar), .conta_time(conta_time), .partida_tx(partida_tx),
    .conta_prox_char(conta_prox_char), .ganhou(ganhou), .erro(erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_st = 4'd0;
  int         n_mens = 0, n_ptx = 0, n_prox = 0;
  int         b_mens, b_ptx, b_prox;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] all_outs();
    return {zera, zera_time, zera_char, mensurar, conta_time,
            partida_tx, conta_prox_char, ganhou, erro};
  endfunction

  // Monitor: pulse counters and state-sequence scoreboard.
  always @(negedge clock) begin
    if (mensurar === 1'b1)        n_mens++;
    if (partida_tx === 1'b1)      n_ptx++;
    if (conta_prox_char === 1'b1) n_prox++;
    if (db_estado !== prev_st) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_state actual=%0d required=none", db_estado);
      end else begin
        check("state_seq", 32'(db_estado), 32'(exp_q.pop_front()));
      end
      prev_st = db_estado;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [3:0] s);
    exp_q.push_back(s);
  endtask

  task automatic start_game();
    push(4'd1); push(4'd2); push(4'd3);
    iniciar = 1'b1; cyc(1); iniciar = 1'b0;
    cyc(9);
  endtask

  task automatic measure_ok();
    push(4'd4); push(4'd5);
    pronto_medida = 1'b1; cyc(1); pronto_medida = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < 4; k++) begin
      cyc(3);
      if (k < 3) begin
        push(4'd6); push(4'd4); push(4'd5);
      end else begin
        push(4'd7);
      end
      pronto_tx = 1'b1; is_ultimo_char = (k == 3);
      cyc(1);
      pronto_tx = 1'b0; is_ultimo_char = 1'b0;
    end
    check("intervalo_entry_zera_char", 32'(zera_char), 32'd1);
    check("intervalo_entry_conta_time", 32'(conta_time), 32'd0);
    cyc(1);
    check("intervalo_run_zera_char", 32'(zera_char), 32'd0);
    check("intervalo_run_conta_time", 32'(conta_time), 32'd1);
    check("intervalo_state", 32'(db_estado), 32'd7);
  endtask

  task automatic timeout(input logic final_one);
    if (final_one) push(4'd15);
    else begin push(4'd2); push(4'd3); end
    fim_time = 1'b1; cyc(1); fim_time = 1'b0;
    cyc(3);
  endtask

  task automatic interval_fim(input logic win);
    cyc(2);
    if (win) push(4'd8);
    else begin push(4'd2); push(4'd3); end
    fim_time = 1'b1; acertou = win; cyc(1);
    fim_time = 1'b0; acertou = 1'b0;
    cyc(3);
  endtask

  initial begin
    ligar = 0; iniciar = 0; pronto_medida = 0; pronto_tx = 0;
    is_ultimo_char = 0; fim_time = 0; acertou = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_state", 32'(db_estado), 32'd0);
    check("reset_outputs", 32'(all_outs()), 32'd0);
    cyc(2);
    reset = 1'b1;
    ligar = 1'b1;
    cyc(3);
    check("idle_without_iniciar", 32'(db_estado), 32'd0);
    check("idle_outputs", 32'(all_outs()), 32'd0);

    // Full frame, then a non-winning interval, then a winning one.
    b_mens = n_mens; b_ptx = n_ptx; b_prox = n_prox;
    start_game();
    measure_ok();
    send_frame();
    check("frame_partida_tx", 32'(n_ptx - b_ptx), 32'd4);
    check("frame_conta_prox", 32'(n_prox - b_prox), 32'd3);
    check("frame_mensurar", 32'(n_mens - b_mens), 32'd1);
    interval_fim(1'b0);
    check("interval_remeasure", 32'(n_mens - b_mens), 32'd2);
    measure_ok();
    send_frame();
    interval_fim(1'b1);
    check("acerto_state", 32'(db_estado), 32'd8);
    check("acerto_ganhou", 32'(ganhou), 32'd1);
    cyc(5);
    check("acerto_no_mensurar", 32'(n_mens - b_mens), 32'd2);

    // Three consecutive timeouts reach ERRO.
    b_mens = n_mens;
    start_game();
    timeout(1'b0);
    timeout(1'b0);
    timeout(1'b1);
    check("erro_mensurar_count", 32'(n_mens - b_mens), 32'd3);
    check("erro_state", 32'(db_estado), 32'd15);
    check("erro_flag", 32'(erro), 32'd1);
    push(4'd1); push(4'd2); push(4'd3);
    iniciar = 1'b1; cyc(1); iniciar = 1'b0;
    check("prepara_state", 32'(db_estado), 32'd1);
    check("prepara_zeros", 32'({zera, zera_time, zera_char}), 32'd7);
    cyc(4);

    // Simultaneous pronto_medida/fim_time after two timeouts: no ERRO.
    timeout(1'b0);
    timeout(1'b0);
    push(4'd4); push(4'd5);
    pronto_medida = 1'b1; fim_time = 1'b1; cyc(1);
    pronto_medida = 1'b0; fim_time = 1'b0;
    send_frame();
    interval_fim(1'b0);
    timeout(1'b0);
    timeout(1'b0);
    check("retry_cleared_state", 32'(db_estado), 32'd3);
    check("retry_cleared_erro", 32'(erro), 32'd0);
    timeout(1'b1);
    check("retry_third_erro", 32'(db_estado), 32'd15);

    // ligar dropped mid-transmission.
    start_game();
    measure_ok();
    cyc(3);
    push(4'd0);
    ligar = 1'b0; cyc(1);
    check("ligar_off_state", 32'(db_estado), 32'd0);
    b_ptx = n_ptx;
    pronto_tx = 1'b1; is_ultimo_char = 1'b1; cyc(1);
    pronto_tx = 1'b0; is_ultimo_char = 1'b0;
    cyc(3);
    check("ligar_off_ignores_tx", 32'(db_estado), 32'd0);
    check("ligar_off_no_partida", 32'(n_ptx - b_ptx), 32'd0);
    ligar = 1'b1; cyc(1);

    // Asynchronous reset mid ESPERA_TX.
    start_game();
    measure_ok();
    cyc(3);
    check("pre_reset_espera_tx", 32'(db_estado), 32'd5);
    push(4'd0);
    #1 reset = 1'b0;
    #1;
    check("async_reset_state", 32'(db_estado), 32'd0);
    check("async_reset_outputs", 32'(all_outs()), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check("post_reset_idle", 32'(db_estado), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
